// File: rtl/dm_bytewise.sv
// rtl/dm_bytewise.sv - byte/half/word data memory with clear engine and debug read port
module dm_bytewise #(
  parameter int DEPTH      = 1024,
  parameter bit INIT_CLEAR = 1'b1,
  parameter int DBG_AW     = 4
) (
  input  logic              clk,
  input  logic              clr_n,
  input  logic [31:0]       addr,
  input  logic [31:0]       din,
  input  logic              we,
  input  logic [1:0]        size,
  input  logic              sign_ext,
  output logic [31:0]       dout,
  output logic              misalign,
  input  logic              clear_req,
  output logic              busy,
  input  logic [DBG_AW-1:0] dbg_addr,
  output logic [31:0]       dbg_dout
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  logic [31:0]   mem [DEPTH];
  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] widx;
  logic [AW-1:0] didx;
  logic [31:0]   word;
  logic [7:0]    rbyte;
  logic [15:0]   rhalf;
  logic [3:0]    be;
  logic [31:0]   wdata;
  logic          wr_en;
  logic          unused_addr;

  // upper address bits are ignored so accesses wrap modulo DEPTH
  assign widx        = addr[AW+1:2];
  assign didx        = AW'(dbg_addr);
  assign word        = mem[widx];
  assign dbg_dout    = mem[didx];
  assign busy        = (state_q == CLEAR);
  assign unused_addr = ^addr[31:AW+2];

  // alignment fault: halves need addr[0]==0, words need addr[1:0]==0
  always_comb begin
    misalign = ((size == 2'b01) && addr[0]) || (size[1] && (addr[1:0] != 2'b00));
  end

  // little-endian lane select plus sign/zero extension; faulted loads return zero
  always_comb begin
    rbyte = word[7:0];
    case (addr[1:0])
      2'b01:   rbyte = word[15:8];
      2'b10:   rbyte = word[23:16];
      2'b11:   rbyte = word[31:24];
      default: rbyte = word[7:0];
    endcase
    rhalf = addr[1] ? word[31:16] : word[15:0];
    dout  = 32'd0;
    if (!misalign) begin
      case (size)
        2'b00:   dout = sign_ext ? {{24{rbyte[7]}}, rbyte} : {24'd0, rbyte};
        2'b01:   dout = sign_ext ? {{16{rhalf[15]}}, rhalf} : {16'd0, rhalf};
        default: dout = word;
      endcase
    end
  end

  // store lane enables and replicated store data so each lane sees its own slice
  always_comb begin
    be    = 4'b1111;
    wdata = din;
    case (size)
      2'b00: begin
        be    = 4'b0001 << addr[1:0];
        wdata = {4{din[7:0]}};
      end
      2'b01: begin
        be    = addr[1] ? 4'b1100 : 4'b0011;
        wdata = {2{din[15:0]}};
      end
      default: ;
    endcase
    wr_en = we && !misalign && !busy;
  end

  // clear engine next state: one word per cycle, requests while clearing are ignored
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clear_req) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == AW'(DEPTH - 1)) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // clear engine state register; reset restarts or aborts the sweep
  always_ff @(posedge clk or negedge clr_n) begin
    if (!clr_n) begin
      cnt_q <= '0;
      if (INIT_CLEAR) state_q <= CLEAR;
      else            state_q <= IDLE;
    end else begin
      cnt_q   <= cnt_d;
      state_q <= state_d;
    end
  end

  // array write port: clear sweep has priority, CPU stores are lane-masked
  always_ff @(posedge clk) begin
    if (busy) begin
      mem[cnt_q] <= '0;
    end else if (wr_en) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem[widx][8*i +: 8] <= wdata[8*i +: 8];
      end
    end
  end

endmodule

// File: tb/tb_dm_bytewise.sv
// tb/tb_dm_bytewise.sv - randomized self-checking bench for dm_bytewise
module tb_dm_bytewise;

  localparam int DEPTH = 1024;
  localparam int NB    = 4 * DEPTH;

  logic        clk = 1'b0;
  logic        clr_n1, clr_n0, we1, we0, clear_req1, clear_req0, sign_ext;
  logic [31:0] addr, din;
  logic [1:0]  size;
  logic [3:0]  dbg_addr;
  logic [31:0] dout1, dout0, dbg_dout1, dbg_dout0;
  logic        misalign1, misalign0, busy1, busy0;

  int errors = 0;
  int checks = 0;

  logic [7:0] ref1 [NB];
  logic [7:0] ref0 [NB];

  always #5 clk = ~clk;

  dm_bytewise #(.DEPTH(DEPTH), .INIT_CLEAR(1'b1), .DBG_AW(4)) dut1 (
    .clk(clk), .clr_n(clr_n1), .addr(addr), .din(din), .we(we1), .size(size),
    .sign_ext(sign_ext), .dout(dout1), .misalign(misalign1), .clear_req(clear_req1),
    .busy(busy1), .dbg_addr(dbg_addr), .dbg_dout(dbg_dout1)
  );

  dm_bytewise #(.DEPTH(DEPTH), .INIT_CLEAR(1'b0), .DBG_AW(4)) dut0 (
    .clk(clk), .clr_n(clr_n0), .addr(addr), .din(din), .we(we0), .size(size),
    .sign_ext(sign_ext), .dout(dout0), .misalign(misalign0), .clear_req(clear_req0),
    .busy(busy0), .dbg_addr(dbg_addr), .dbg_dout(dbg_dout0)
  );

  // reference model: byte-addressed array, little-endian, natural alignment
  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  function automatic bit model_mis(input logic [31:0] a, input logic [1:0] sz);
    return (a % nbytes(sz)) != 0;
  endfunction

  function automatic logic [31:0] model_load(input bit inst, input logic [31:0] a,
                                             input logic [1:0] sz, input logic sx);
    int nb, base;
    logic [31:0] v;
    logic [7:0]  b;
    nb = nbytes(sz);
    if (model_mis(a, sz)) return 32'd0;
    base = int'(a % 32'(NB));
    v = 32'd0;
    for (int k = 0; k < nb; k++) begin
      b = inst ? ref1[base + k] : ref0[base + k];
      v = v | (32'(b) << (8 * k));
    end
    if (nb < 4 && sx && v[8*nb-1]) v = v | (32'hFFFF_FFFF << (8 * nb));
    return v;
  endfunction

  task automatic model_store(input bit inst, input logic [31:0] a, input logic [31:0] d,
                             input logic [1:0] sz);
    int nb, base;
    nb = nbytes(sz);
    if (!model_mis(a, sz)) begin
      base = int'(a % 32'(NB));
      for (int k = 0; k < nb; k++) begin
        if (inst) ref1[base + k] = d[8*k +: 8];
        else      ref0[base + k] = d[8*k +: 8];
      end
    end
  endtask

  task automatic model_clear(input bit inst, input int lo, input int hi);
    for (int i = 4 * lo; i < 4 * hi; i++) begin
      if (inst) ref1[i] = 8'd0;
      else      ref0[i] = 8'd0;
    end
  endtask

  task automatic store(input bit inst, input logic [31:0] a, input logic [31:0] d,
                       input logic [1:0] sz);
    @(negedge clk);
    addr = a; din = d; size = sz;
    if (inst) we1 = 1'b1; else we0 = 1'b1;
    @(posedge clk); #1;
    we1 = 1'b0; we0 = 1'b0;
  endtask

  task automatic load(input logic [31:0] a, input logic [1:0] sz, input logic sx);
    @(negedge clk);
    addr = a; size = sz; sign_ext = sx;
    #1;
  endtask

  task automatic pulse_clear(input bit inst);
    @(negedge clk);
    if (inst) clear_req1 = 1'b1; else clear_req0 = 1'b1;
    @(posedge clk); #1;
    clear_req1 = 1'b0; clear_req0 = 1'b0;
  endtask

  task automatic test_reset;
    int n;
    repeat (3) @(posedge clk);
    #1;
    checks++; if (busy1 !== 1'b1) $display("FAIL reset_busy_init1 got=%b exp=1", busy1);
    checks++; if (busy0 !== 1'b0) $display("FAIL reset_busy_init0 got=%b exp=0", busy0);
    errors += (busy1 !== 1'b1) + (busy0 !== 1'b0);
    clr_n1 = 1'b1; clr_n0 = 1'b1;
    clear_req0 = 1'b1;
    we1 = 1'b1; addr = 32'd20; size = 2'b10; din = $urandom | 32'd1;
    n = 0;
    while (busy1 === 1'b1 && n < 2000) begin
      @(posedge clk); #1;
      n++;
      clear_req0 = 1'b0;
      din = $urandom | 32'd1;
      if (busy1 !== 1'b1) we1 = 1'b0;
      if (n == 1) begin
        checks++;
        if (busy0 !== 1'b1) begin errors++; $display("FAIL clear0_start got=%b exp=1", busy0); end
      end
    end
    we1 = 1'b0;
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL init_clear_len got=%0d exp=%0d", n, DEPTH); end
    n = 0;
    while (busy0 === 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL clear0_done got=%b exp=0", busy0); end
    model_clear(1'b1, 0, DEPTH);
    model_clear(1'b0, 0, DEPTH);
    load(32'd20, 2'b10, 1'b0);
    checks++;
    if (dout1 !== 32'd0) begin errors++; $display("FAIL busy_store_dropped got=%h exp=0", dout1); end
  endtask

  task automatic test_word_byte;
    store(1'b1, 32'h40, 32'h1122_3344, 2'b10);
    model_store(1'b1, 32'h40, 32'h1122_3344, 2'b10);
    store(1'b1, 32'h42, 32'h0000_00AA, 2'b00);
    model_store(1'b1, 32'h42, 32'h0000_00AA, 2'b00);
    load(32'h40, 2'b10, 1'b1);
    checks++;
    if (dout1 !== 32'h11AA_3344) begin errors++; $display("FAIL lw_after_sb got=%h exp=11aa3344", dout1); end
    load(32'h42, 2'b00, 1'b1);
    checks++;
    if (dout1 !== 32'hFFFF_FFAA) begin errors++; $display("FAIL lb got=%h exp=ffffffaa", dout1); end
    load(32'h42, 2'b00, 1'b0);
    checks++;
    if (dout1 !== 32'h0000_00AA) begin errors++; $display("FAIL lbu got=%h exp=000000aa", dout1); end
  endtask

  task automatic test_half;
    store(1'b1, 32'h46, 32'h0000_BEEF, 2'b01);
    model_store(1'b1, 32'h46, 32'h0000_BEEF, 2'b01);
    load(32'h44, 2'b10, 1'b0);
    checks++;
    if (dout1 !== 32'hBEEF_0000) begin errors++; $display("FAIL lw_after_sh got=%h exp=beef0000", dout1); end
    load(32'h46, 2'b01, 1'b1);
    checks++;
    if (dout1 !== 32'hFFFF_BEEF) begin errors++; $display("FAIL lh got=%h exp=ffffbeef", dout1); end
    load(32'h46, 2'b01, 1'b0);
    checks++;
    if (dout1 !== 32'h0000_BEEF) begin errors++; $display("FAIL lhu got=%h exp=0000beef", dout1); end
  endtask

  task automatic test_misalign;
    load(32'h41, 2'b10, 1'b0);
    checks++;
    if (misalign1 !== 1'b1 || dout1 !== 32'd0) begin
      errors++; $display("FAIL sw_misalign_flag got=%b/%h exp=1/0", misalign1, dout1);
    end
    store(1'b1, 32'h41, 32'hDEAD_BEEF, 2'b10);
    load(32'h40, 2'b10, 1'b0);
    checks++;
    if (dout1 !== 32'h11AA_3344) begin errors++; $display("FAIL misaligned_store_suppressed got=%h exp=11aa3344", dout1); end
    load(32'h44, 2'b10, 1'b0);
    checks++;
    if (dout1 !== 32'hBEEF_0000) begin errors++; $display("FAIL misaligned_store_next got=%h exp=beef0000", dout1); end
    load(32'h43, 2'b01, 1'b1);
    checks++;
    if (misalign1 !== 1'b1) begin errors++; $display("FAIL lh_misalign got=%b exp=1", misalign1); end
    store(1'b1, 32'h1040, 32'h5A5A_5A5A, 2'b10);
    model_store(1'b1, 32'h1040, 32'h5A5A_5A5A, 2'b10);
    load(32'h40, 2'b10, 1'b0);
    checks++;
    if (dout1 !== 32'h5A5A_5A5A) begin errors++; $display("FAIL addr_wrap got=%h exp=5a5a5a5a", dout1); end
  endtask

  task automatic test_random;
    logic [31:0] a, d, e;
    logic [1:0]  sz;
    logic        sx;
    for (int it = 0; it < 300; it++) begin
      a  = ($urandom << 12) | 32'($urandom_range(0, 127));
      sz = 2'($urandom_range(0, 3));
      sx = 1'($urandom_range(0, 1));
      dbg_addr = 4'($urandom_range(0, 15));
      load(a, sz, sx);
      e = model_load(1'b1, a, sz, sx);
      checks++;
      if (dout1 !== e) begin errors++; $display("FAIL rand_load a=%h sz=%0d got=%h exp=%h", a, sz, dout1, e); end
      checks++;
      if (misalign1 !== model_mis(a, sz)) begin
        errors++; $display("FAIL rand_misalign a=%h sz=%0d got=%b exp=%b", a, sz, misalign1, model_mis(a, sz));
      end
      e = model_load(1'b1, 32'(dbg_addr) * 4, 2'b10, 1'b0);
      checks++;
      if (dbg_dout1 !== e) begin errors++; $display("FAIL rand_dbg idx=%0d got=%h exp=%h", dbg_addr, dbg_dout1, e); end
      if ($urandom_range(0, 1) == 1) begin
        d = $urandom;
        store(1'b1, a, d, sz);
        model_store(1'b1, a, d, sz);
      end
    end
  endtask

  task automatic fill_low(input bit inst, input int base);
    logic [31:0] d;
    for (int w = base; w < base + 16; w++) begin
      d = $urandom | 32'd1;
      store(inst, 32'(w * 4), d, 2'b10);
      model_store(inst, 32'(w * 4), d, 2'b10);
    end
  endtask

  task automatic test_clear_req;
    int n;
    fill_low(1'b1, 0);
    dbg_addr = 4'd7;
    @(negedge clk);
    checks++;
    if (dbg_dout1 !== model_load(1'b1, 32'd28, 2'b10, 1'b0)) begin
      errors++; $display("FAIL fill_check got=%h exp=%h", dbg_dout1, model_load(1'b1, 32'd28, 2'b10, 1'b0));
    end
    pulse_clear(1'b1);
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL clear_req_busy got=%b exp=1", busy1); end
    n = 0;
    while (busy1 === 1'b1 && n < 2000) begin
      clear_req1 = (n == 10);
      we1 = (n == 20); addr = 32'd12; din = 32'hFFFF_FFFF; size = 2'b10;
      @(posedge clk); #1;
      n++;
    end
    clear_req1 = 1'b0; we1 = 1'b0;
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL clear_req_len got=%0d exp=%0d", n, DEPTH); end
    model_clear(1'b1, 0, DEPTH);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); dbg_addr = 4'(i); #1;
      checks++;
      if (dbg_dout1 !== 32'd0) begin errors++; $display("FAIL cleared_dbg idx=%0d got=%h exp=0", i, dbg_dout1); end
    end
  endtask

  task automatic test_reset_mid_clear;
    int n;
    fill_low(1'b1, 0);
    pulse_clear(1'b1);
    n = 0;
    while (busy1 === 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    clr_n1 = 1'b0; #1;
    checks++;
    if (busy1 !== 1'b1) begin errors++; $display("FAIL midreset_busy1 got=%b exp=1", busy1); end
    repeat (2) @(posedge clk);
    #1;
    clr_n1 = 1'b1;
    n = 0;
    while (busy1 === 1'b1 && n < 2000) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != DEPTH) begin errors++; $display("FAIL restart_len got=%0d exp=%0d", n, DEPTH); end
    model_clear(1'b1, 0, DEPTH);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk); dbg_addr = 4'(i); #1;
      checks++;
      if (dbg_dout1 !== 32'd0) begin errors++; $display("FAIL restart_dbg idx=%0d got=%h exp=0", i, dbg_dout1); end
    end
  endtask

  task automatic test_abort_mid_clear;
    int n;
    logic [31:0] e;
    fill_low(1'b0, 0);
    fill_low(1'b0, 300);
    pulse_clear(1'b0);
    n = 0;
    while (busy0 === 1'b1 && n < 300) begin @(posedge clk); #1; n++; end
    checks++;
    if (n != 300) begin errors++; $display("FAIL abort_reach got=%0d exp=300", n); end
    clr_n0 = 1'b0; #1;
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_busy got=%b exp=0", busy0); end
    repeat (2) @(posedge clk);
    #1;
    clr_n0 = 1'b1;
    model_clear(1'b0, 0, 300);
    for (int w = 0; w < 316; w = (w == 15) ? 300 : w + 1) begin
      load(32'(w * 4), 2'b10, 1'b0);
      e = model_load(1'b0, 32'(w * 4), 2'b10, 1'b0);
      checks++;
      if (dout0 !== e) begin errors++; $display("FAIL abort_word idx=%0d got=%h exp=%h", w, dout0, e); end
    end
    checks++;
    if (busy0 !== 1'b0) begin errors++; $display("FAIL abort_stays_idle got=%b exp=0", busy0); end
  endtask

  initial begin
    clr_n1 = 1'b0; clr_n0 = 1'b0;
    we1 = 1'b0; we0 = 1'b0; clear_req1 = 1'b0; clear_req0 = 1'b0;
    addr = 32'd0; din = 32'd0; size = 2'b10; sign_ext = 1'b0; dbg_addr = 4'd0;
    test_reset;
    test_word_byte;
    test_half;
    test_misalign;
    test_random;
    test_clear_req;
    test_reset_mid_clear;
    test_abort_mid_clear;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
